// File: rtl/cav_freq_mux_if.sv
// Port bundle for cav_freq_mux: fine-sample stream, coarse-target host writes,
// slew limit, and the saturated detuning result stream.
interface cav_freq_mux_if #(
  parameter int NCH = 4,
  parameter int FW  = 18,
  parameter int CW  = 28,
  parameter int SW  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  in_valid;
  logic [CHW-1:0]        in_ch;
  logic signed [FW-1:0]  fine;
  logic                  cf_we;
  logic [CHW-1:0]        cf_addr;
  logic signed [CW-1:0]  cf_data;
  logic [SW-1:0]         slew;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [CW-1:0]  out;
  logic [NCH-1:0]        ramping;

  modport master (
    output in_valid, in_ch, fine, cf_we, cf_addr, cf_data, slew,
    input  out_valid, out_ch, out, ramping
  );

  modport slave (
    input  in_valid, in_ch, fine, cf_we, cf_addr, cf_data, slew,
    output out_valid, out_ch, out, ramping
  );
endinterface

// File: rtl/cav_freq_mux.sv
// Time-multiplexed cavity detuning combiner: per-channel slew-limited coarse ramp
// plus scaled fine term, rounded and saturated, two-stage pipeline.
module cav_freq_mux #(
  parameter int NCH      = 4,
  parameter int FW       = 18,
  parameter int CW       = 28,
  parameter int DF_SCALE = 0,
  parameter int SW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  cav_freq_mux_if.slave    bus
);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW   = CW + 1;
  localparam int MW   = (DW > SW) ? DW + 1 : SW + 1;
  localparam int SUMW = CW + 4;
  localparam logic signed [CW+1:0] OMAX = {3'b000, {(CW-1){1'b1}}};
  localparam logic signed [CW+1:0] OMIN = {3'b111, {(CW-1){1'b0}}};

  logic signed [CW-1:0] tgt_q [NCH];
  logic signed [CW-1:0] tgt_d [NCH];
  logic signed [CW-1:0] cur_q [NCH];
  logic signed [CW-1:0] cur_d [NCH];
  logic [NCH-1:0]       ramping_q, ramping_d;

  logic                 in_acc, we_acc;
  logic signed [CW-1:0] sel_cur, sel_tgt, step_cur;
  logic signed [DW-1:0] diff;
  logic [DW-1:0]        diff_mag;
  logic                 snap;
  logic signed [MW-1:0] cur_mw, slew_mw, step_wide;

  logic                 p1_valid_q, p1_valid_d;
  logic [CHW-1:0]       p1_ch_q, p1_ch_d;
  logic signed [FW-1:0] p1_fine_q, p1_fine_d;
  logic signed [CW-1:0] p1_cur_q, p1_cur_d;

  logic                 out_valid_q, out_valid_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic signed [CW-1:0] out_q, out_d;

  logic signed [SUMW-1:0] fine_ext, fine_sh, cur_ext, sum;
  logic signed [CW+1:0]   r;
  logic signed [CW-1:0]   clamped;

  assign in_acc = bus.in_valid && (32'(bus.in_ch) < NCH);
  assign we_acc = bus.cf_we && (32'(bus.cf_addr) < NCH);

  // Stage 1: one slew step for the addressed channel, using pre-write tgt.
  always_comb begin
    sel_cur = '0;
    sel_tgt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.in_ch == CHW'(k)) begin
        sel_cur = cur_q[k];
        sel_tgt = tgt_q[k];
      end
    end
    diff      = {sel_tgt[CW-1], sel_tgt} - {sel_cur[CW-1], sel_cur};
    diff_mag  = diff[DW-1] ? DW'(-diff) : DW'(diff);
    snap      = (bus.slew == '0) ||
                ({{(MW-DW){1'b0}}, diff_mag} <= {{(MW-SW){1'b0}}, bus.slew});
    cur_mw    = {{(MW-CW){sel_cur[CW-1]}}, sel_cur};
    slew_mw   = {{(MW-SW){1'b0}}, bus.slew};
    step_wide = diff[DW-1] ? (cur_mw - slew_mw) : (cur_mw + slew_mw);
    step_cur  = snap ? sel_tgt : step_wide[CW-1:0];
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic wr_hit, up_hit;
    assign wr_hit        = we_acc && (bus.cf_addr == CHW'(gi));
    assign up_hit        = in_acc && (bus.in_ch == CHW'(gi));
    assign tgt_d[gi]     = wr_hit ? bus.cf_data : tgt_q[gi];
    assign cur_d[gi]     = up_hit ? step_cur : cur_q[gi];
    assign ramping_d[gi] = (cur_d[gi] != tgt_d[gi]);
  end

  always_comb begin
    p1_valid_d = in_acc;
    p1_ch_d    = p1_ch_q;
    p1_fine_d  = p1_fine_q;
    p1_cur_d   = p1_cur_q;
    if (in_acc) begin
      p1_ch_d   = bus.in_ch;
      p1_fine_d = bus.fine;
      p1_cur_d  = step_cur;
    end
  end

  // Stage 2: 4*cur + scaled fine with +2 rounding, /4, then saturate.
  always_comb begin
    fine_ext = {{(SUMW-FW){p1_fine_q[FW-1]}}, p1_fine_q};
    fine_sh  = fine_ext <<< DF_SCALE;
    cur_ext  = {{2{p1_cur_q[CW-1]}}, p1_cur_q, 2'b00};
    sum      = fine_sh + cur_ext + SUMW'(2);
    r        = sum[SUMW-1:2];
    if (r > OMAX) begin
      clamped = OMAX[CW-1:0];
    end else if (r < OMIN) begin
      clamped = OMIN[CW-1:0];
    end else begin
      clamped = r[CW-1:0];
    end
    out_valid_d = p1_valid_q;
    out_ch_d    = p1_valid_q ? p1_ch_q : out_ch_q;
    out_d       = p1_valid_q ? clamped : out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        tgt_q[k] <= '0;
        cur_q[k] <= '0;
      end
      ramping_q   <= '0;
      p1_valid_q  <= 1'b0;
      p1_ch_q     <= '0;
      p1_fine_q   <= '0;
      p1_cur_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_q       <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        tgt_q[k] <= tgt_d[k];
        cur_q[k] <= cur_d[k];
      end
      ramping_q   <= ramping_d;
      p1_valid_q  <= p1_valid_d;
      p1_ch_q     <= p1_ch_d;
      p1_fine_q   <= p1_fine_d;
      p1_cur_q    <= p1_cur_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out       = out_q;
  assign bus.ramping   = ramping_q;
endmodule
